// File: rtl/axi_ni_request_scheduler.sv
// axi_ni_request_scheduler
// Control FSM for the initiator NI request path. Round-robin arbitrates
// between the AXI AR and AW channels, strobes the header register capture,
// serialises the header into HEADER_FLITS flits and, for writes, streams
// the W beats through as body/tail flits.
// Optional build macro: AXI_NI_REQ_WLAST_CHECK_EN enables the sticky
// w_last-versus-beat-counter mismatch flag on o_protocol_err.

module axi_ni_request_scheduler #(
    parameter int unsigned HEADER_FLITS = 2,
    parameter int unsigned BLEN_WD      = 8,
    parameter int unsigned IDX_WD       = 2
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               i_ar_valid,
    output logic               o_ar_ready,
    input  logic               i_aw_valid,
    output logic               o_aw_ready,
    input  logic [BLEN_WD-1:0] i_aw_len,
    input  logic               i_w_valid,
    input  logic               i_w_last,
    output logic               o_w_ready,

    output logic               o_sample_header,
    output logic               o_hdr_sel,
    output logic [IDX_WD-1:0]  o_hdr_flit_idx,
    output logic               o_flit_src,
    output logic               o_flit_valid,
    input  logic               i_flit_ready,
    output logic [1:0]         o_flit_type,
    output logic               o_busy,
    output logic               o_protocol_err
);

    localparam logic [IDX_WD-1:0] HDR_LAST    = IDX_WD'(HEADER_FLITS - 1);
    localparam logic [1:0]        FT_BODY     = 2'b00;
    localparam logic [1:0]        FT_HEAD     = 2'b01;
    localparam logic [1:0]        FT_TAIL     = 2'b10;
    localparam logic [1:0]        FT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_WDATA  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // hdr_sel encoding is reused for last_grant: 0 = AR, 1 = AW
    logic               r_last_grant;
    logic               r_hdr_sel;
    logic [BLEN_WD-1:0] r_beat_cnt_max;
    logic [BLEN_WD-1:0] r_beat_cnt;
    logic [IDX_WD-1:0]  r_hdr_cnt;

    logic               w_grant_ar;
    logic               w_grant_aw;
    logic               w_hdr_acc;
    logic               w_beat_acc;
    logic               w_hdr_last;
    logic               w_beat_last;

    assign w_hdr_last  = (r_hdr_cnt == HDR_LAST);
    assign w_beat_last = (r_beat_cnt == r_beat_cnt_max);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; handshake outputs are combinational
    // so the address and W channels see zero-latency accepts
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_ar      = 1'b0;
        w_grant_aw      = 1'b0;
        w_hdr_acc       = 1'b0;
        w_beat_acc      = 1'b0;
        o_ar_ready      = 1'b0;
        o_aw_ready      = 1'b0;
        o_w_ready       = 1'b0;
        o_sample_header = 1'b0;
        o_hdr_sel       = r_hdr_sel;
        o_hdr_flit_idx  = r_hdr_cnt;
        o_flit_src      = 1'b0;
        o_flit_valid    = 1'b0;
        o_flit_type     = FT_BODY;
        o_busy          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // On a tie the channel not granted last time wins
                w_grant_ar      = i_ar_valid & (~i_aw_valid | r_last_grant);
                w_grant_aw      = i_aw_valid & (~i_ar_valid | ~r_last_grant);
                o_ar_ready      = w_grant_ar;
                o_aw_ready      = w_grant_aw;
                o_sample_header = w_grant_ar | w_grant_aw;
                o_hdr_sel       = w_grant_aw;
                if (w_grant_ar || w_grant_aw) begin
                    w_state_nxt = ST_HEADER;
                end
            end

            ST_HEADER: begin
                o_busy       = 1'b1;
                o_flit_valid = 1'b1;
                w_hdr_acc    = i_flit_ready;
                if (r_hdr_cnt == '0) begin
                    o_flit_type = (w_hdr_last && !r_hdr_sel) ? FT_HEADTAIL : FT_HEAD;
                end else if (w_hdr_last && !r_hdr_sel) begin
                    o_flit_type = FT_TAIL;
                end else begin
                    o_flit_type = FT_BODY;
                end
                if (w_hdr_acc && w_hdr_last) begin
                    w_state_nxt = r_hdr_sel ? ST_WDATA : ST_IDLE;
                end
            end

            ST_WDATA: begin
                o_busy       = 1'b1;
                o_flit_src   = 1'b1;
                o_flit_valid = i_w_valid;
                o_w_ready    = i_flit_ready;
                w_beat_acc   = i_w_valid & i_flit_ready;
                o_flit_type  = w_beat_last ? FT_TAIL : FT_BODY;
                if (w_beat_acc && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and the header/beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant   <= 1'b1;
            r_hdr_sel      <= 1'b0;
            r_beat_cnt_max <= '0;
            r_beat_cnt     <= '0;
            r_hdr_cnt      <= '0;
        end else begin
            if (w_grant_ar || w_grant_aw) begin
                r_hdr_sel    <= w_grant_aw;
                r_last_grant <= w_grant_aw;
                if (w_grant_aw) begin
                    r_beat_cnt_max <= i_aw_len;
                end
            end
            if (w_hdr_acc) begin
                r_hdr_cnt <= w_hdr_last ? '0 : r_hdr_cnt + IDX_WD'(1);
            end
            if (w_beat_acc) begin
                r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + BLEN_WD'(1);
            end
        end
    end

`ifdef AXI_NI_REQ_WLAST_CHECK_EN
    logic r_protocol_err;

    // Sticky flag: w_last disagrees with the beat counter on an accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_protocol_err <= 1'b0;
        end else if (w_beat_acc && (i_w_last != w_beat_last)) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign o_protocol_err = r_protocol_err;
`else
    logic w_unused_w_last;

    assign w_unused_w_last = i_w_last;
    assign o_protocol_err  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ni_request_scheduler.sv
// Directed bench for axi_ni_request_scheduler: a cycle-by-cycle vector
// table covering read, write, round-robin, backpressure and mid-packet
// reset, followed by hand-written full-range burst and w_last sequences.

module tb_axi_ni_request_scheduler;

    localparam int unsigned HEADER_FLITS = 2;
    localparam int unsigned BLEN_WD      = 8;
    localparam int unsigned IDX_WD       = 2;

    logic               clk;
    logic               rst;
    logic               ar_valid, ar_ready;
    logic               aw_valid, aw_ready;
    logic [BLEN_WD-1:0] aw_len;
    logic               w_valid, w_last, w_ready;
    logic               sample_header, hdr_sel;
    logic [IDX_WD-1:0]  hdr_flit_idx;
    logic               flit_src, flit_valid, flit_ready;
    logic [1:0]         flit_type;
    logic               busy, protocol_err;

    int errors = 0;
    int checks = 0;

    axi_ni_request_scheduler #(
        .HEADER_FLITS (HEADER_FLITS),
        .BLEN_WD      (BLEN_WD),
        .IDX_WD       (IDX_WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_ar_valid      (ar_valid),
        .o_ar_ready      (ar_ready),
        .i_aw_valid      (aw_valid),
        .o_aw_ready      (aw_ready),
        .i_aw_len        (aw_len),
        .i_w_valid       (w_valid),
        .i_w_last        (w_last),
        .o_w_ready       (w_ready),
        .o_sample_header (sample_header),
        .o_hdr_sel       (hdr_sel),
        .o_hdr_flit_idx  (hdr_flit_idx),
        .o_flit_src      (flit_src),
        .o_flit_valid    (flit_valid),
        .i_flit_ready    (flit_ready),
        .o_flit_type     (flit_type),
        .o_busy          (busy),
        .o_protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef AXI_NI_REQ_WLAST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // One cycle of stimulus and the outputs expected during that cycle.
    // exp = {ar_rdy, aw_rdy, w_rdy, smp, sel, idx[1:0], src, fv, type[1:0], busy, err}
    typedef struct {
        logic               rst;
        logic               arv;
        logic               awv;
        logic [BLEN_WD-1:0] len;
        logic               wv;
        logic               wl;
        logic               fr;
        logic [13:0]        exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic rst_i, input logic arv, input logic awv, input int len,
        input logic wv, input logic wl, input logic fr,
        input logic arr, input logic awr, input logic wr, input logic smp,
        input logic sel, input logic [1:0] idx, input logic src, input logic fv,
        input logic [1:0] typ, input logic bsy);
        vec_t v;
        v.rst = rst_i;
        v.arv = arv;
        v.awv = awv;
        v.len = BLEN_WD'(len);
        v.wv  = wv;
        v.wl  = wl;
        v.fr  = fr;
        v.exp = {arr, awr, wr, smp, sel, idx, src, fv, typ, bsy, 1'b0};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {ar_ready, aw_ready, w_ready, sample_header, hdr_sel, hdr_flit_idx,
                flit_src, flit_valid, flit_type, busy, protocol_err};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic arv, input logic awv, input int len,
                         input logic wv, input logic wl, input logic fr);
        rst        = r;
        ar_valid   = arv;
        aw_valid   = awv;
        aw_len     = BLEN_WD'(len);
        w_valid    = wv;
        w_last     = wl;
        flit_ready = fr;
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //                rst arv awv len wv wl fr | arr awr wr smp sel idx   src fv typ    busy
        // read, 2 header flits
        vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1,   1, 0, 0, 1, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd1, 0, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        // write aw_len=3
        vecs.push_back(mkv(0, 0, 1, 3, 1, 0, 1,   0, 1, 0, 1, 1, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 1, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        // reset, then AR and AW both held: AR, AW, AR, AW
        vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   1, 0, 0, 1, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd1, 0, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 1, 0, 1, 1, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 1, 1, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   1, 0, 0, 1, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd1, 0, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 1, 0, 1, 1, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 1, 1, 0, 1, 1, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        // write aw_len=3 with header backpressure and W gaps
        vecs.push_back(mkv(0, 0, 1, 3, 0, 0, 0,   0, 1, 0, 1, 1, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 0,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 1,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 0,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 1,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 0, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 0, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 0, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 0, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 1, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        // reset during the 2nd W beat, then a normal read
        vecs.push_back(mkv(0, 0, 1, 3, 1, 0, 1,   0, 1, 0, 1, 1, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 0, 0, 1, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 0, 0, 1, 2'd1, 0, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(1, 0, 0, 3, 1, 0, 1,   0, 0, 1, 0, 1, 2'd0, 1, 1, 2'b00, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 1,   1, 0, 0, 1, 0, 2'd0, 0, 0, 2'b00, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 1, 2'b01, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd1, 0, 1, 2'b10, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd0, 0, 0, 2'b00, 0));

        // Apply inputs after the falling edge, sample 1 ns later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].arv, vecs[i].awv, int'(vecs[i].len),
                  vecs[i].wv, vecs[i].wl, vecs[i].fr);
            #1;
            chk($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
        end

        // Full-range burst: 256 beats, tail only on the last one
        @(negedge clk);
        drive(0, 0, 1, 255, 1, 0, 1);
        #1 chk("full_grant", 16'(aw_ready), 16'd1);
        @(negedge clk);
        drive(0, 0, 0, 255, 1, 0, 1);
        #1 chk("full_hdr0", 16'(flit_type), 16'b01);
        @(negedge clk);
        #1 chk("full_hdr1", 16'(flit_type), 16'b00);
        for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            w_last = (b == 255);
            #1;
            chk($sformatf("full_beat%0d", b), 16'({w_ready, flit_valid, flit_src, flit_type}),
                16'({1'b1, 1'b1, 1'b1, (b == 255) ? 2'b10 : 2'b00}));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1 chk("full_done", 16'({busy, protocol_err}), 16'b00);

        // w_last asserted on beat 0 of a 2-beat burst
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 1, 1, 1, 1, 1);
        #1 chk("wl_grant", 16'({aw_ready, protocol_err}), 16'b10);
        @(negedge clk);
        aw_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("wl_beat0", 16'({w_ready, flit_type, protocol_err}), 16'b1000);
        @(negedge clk);
        #1 chk("wl_beat1", 16'({w_ready, flit_type, protocol_err}), 16'({3'b110, EXP_ERR}));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1 chk("wl_sticky", 16'({busy, protocol_err}), 16'({1'b0, EXP_ERR}));
        @(negedge clk);
        #1 chk("wl_sticky2", 16'(protocol_err), 16'(EXP_ERR));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("wl_cleared", 16'(protocol_err), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_ni_request_scheduler.md
Name: axi_ni_request_scheduler

Overview:
- Control FSM for the initiator NI request path.
- Arbitrates round-robin between the AXI AR and AW channels and strobes sample_header so the request header register captures the winning command.
- Serialises the captured header into HEADER_FLITS NoC flits, then for writes streams W beats as body/tail flits.
- Sits between the AXI slave port and the flit output mux feeding the NI output buffer.

Parameters:
- HEADER_FLITS, 2, number of flits carrying the request header (>=1)
- BLEN_WD, 8, width of AXI burst length field (beats-1)
- IDX_WD, 2, width of hdr_flit_idx (must satisfy 2^IDX_WD >= HEADER_FLITS)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ar_valid  in  1  AXI read address valid
- ar_ready  out  1  AXI read address accept
- aw_valid  in  1  AXI write address valid
- aw_ready  out  1  AXI write address accept
- aw_len  in  BLEN_WD  AXI write burst length (beats-1)
- w_valid  in  1  AXI write data valid
- w_last  in  1  AXI write last beat
- w_ready  out  1  AXI write data accept
- sample_header  out  1  capture strobe to header register
- hdr_sel  out  1  header source mux: 0=AR fields, 1=AW fields
- hdr_flit_idx  out  IDX_WD  header slice selected for current flit
- flit_src  out  1  0=header slice, 1=W data
- flit_valid  out  1  flit valid to NI output buffer
- flit_ready  in  1  NI output buffer accept
- flit_type  out  2  01 head, 00 body, 10 tail, 11 head+tail
- busy  out  1  packet in progress
- protocol_err  out  1  sticky w_last mismatch flag (see Optional Feature)

Behaviour:
- States: IDLE, HEADER, WDATA.
- Reset values:
  - state=IDLE; last_grant=1 (AR wins first tie).
  - All counters 0.
  - ar_ready, aw_ready, w_ready, sample_header, flit_valid, busy, protocol_err = 0.
  - hdr_sel=0, hdr_flit_idx=0, flit_src=0, flit_type=00.
- IDLE:
  - Only AR requesting -> grant AR. Only AW requesting -> grant AW.
  - Both requesting -> grant the channel not granted last.
  - In the grant cycle, combinationally assert the granted *_ready and sample_header, and drive hdr_sel for the winner.
  - On the same edge: latch hdr_sel, latch aw_len into beat_cnt_max (writes only), update last_grant, go to HEADER.
  - The header register captures on that edge, so header data is valid from the first HEADER cycle.
  - Zero-latency accept; at most one address accepted per packet.
- HEADER:
  - flit_valid=1, flit_src=0, hdr_flit_idx=hdr_cnt.
  - hdr_cnt advances on flit_valid&flit_ready.
  - flit_type:
    - hdr_cnt==0: 01 head.
    - Last header flit of a read: 10 tail.
    - HEADER_FLITS==1 on a read: 11 head+tail.
    - Otherwise: 00 body.
  - Last header flit accepted: read -> IDLE; write -> WDATA.
  - hdr_cnt clears on exit.
- WDATA:
  - flit_src=1, flit_valid=w_valid, w_ready=flit_ready (pass-through, no storage).
  - Beat accepted when w_valid&flit_ready; beat_cnt increments.
  - flit_type=10 when beat_cnt==beat_cnt_max, else 00.
  - Tail beat accepted -> IDLE, beat_cnt cleared.
  - Full-range burst (aw_len=2^BLEN_WD-1) must not wrap early; beat_cnt width is BLEN_WD.
- busy=1 in HEADER and WDATA.
- Back-to-back: a new grant may occur in the first IDLE cycle after the tail handshake (one bubble cycle between packets).
- flit_valid, once asserted in HEADER, holds until accepted. In WDATA it follows w_valid.
- ar_ready, aw_ready and sample_header are never asserted outside IDLE.
- w_ready is never asserted outside WDATA.
- Reset mid-packet: immediate return to IDLE; the partial packet is abandoned (NoC side shares the reset).

Optional Feature:
- Macro: AXI_NI_REQ_WLAST_CHECK_EN.
- Defined:
  - Each accepted W beat compares w_last with (beat_cnt==beat_cnt_max).
  - On mismatch, protocol_err sets the next cycle and stays set until rst.
  - Packet termination still follows the counter, never w_last.
- Undefined: protocol_err tied 0 and w_last unused.

Test Plan:
- Read only: ar_valid=1 for one grant, flit_ready=1, HEADER_FLITS=2 -> ar_ready and sample_header high for exactly 1 cycle; flits 01 then 10 with hdr_flit_idx 0,1; IDLE after 3 cycles total.
- Write aw_len=3, w_valid=1, flit_ready=1 -> flit_types 01,00,00,00,00,10 (2 header + 4 data); w_ready high for exactly 4 cycles; busy high for 6 cycles.
- ar_valid and aw_valid held high continuously -> grants alternate AR, AW, AR, AW starting with AR after reset; hdr_sel 0,1,0,1.
- Backpressure: flit_ready toggling 1010 during the header and w_valid gaps in WDATA -> flit_valid never drops in HEADER; no flit lost or duplicated; tail on the 4th data beat.
- rst asserted during the 2nd WDATA beat -> next cycle IDLE, all outputs at reset values; next AR grant proceeds normally.
- With AXI_NI_REQ_WLAST_CHECK_EN: aw_len=1 and w_last=1 on beat 0 -> protocol_err=1 the cycle after beat 0, still sticky after the tail. Without the macro: protocol_err stays 0.
